// File: rtl/instr_fetch.sv
// Instruction fetch: one-edge IR/PC load after MEM_RDY, holds IR while STALL is high, PC_LD redirects.
// Build with INSTR_FETCH_TIMEOUT_EN for a memory-wait timeout (FETCH_ERR pulse, one RETRY bubble).
`timescale 1ns/1ps
module instr_fetch #(
    parameter logic [15:0] RESET_PC    = 16'h3000,
    parameter int          TIMEOUT_CYC = 15
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL,
    input  logic        PC_LD,
    input  logic [15:0] PC_IN,
    input  logic        MEM_RDY,
    input  logic [15:0] MEM_DATA,
    output logic        MEM_REQ,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] IR,
    output logic        IR_VALID,
    output logic [15:0] PC,
    output logic        FETCH_ERR
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_RETRY = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        vld_q, vld_d;
    logic        wait_tick;
    logic        timeout;

    // A wasted FETCH cycle: request outstanding, no data, no redirect.
    assign wait_tick = (state_q == S_FETCH) && !PC_LD && !MEM_RDY;

`ifdef INSTR_FETCH_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic          err_q;

    assign timeout = wait_tick && (cnt_q == CNT_LAST);

    // Leaving FETCH, data arriving or a redirect all drop wait_tick, which clears the count.
    always_ff @(posedge CLK) begin
        if (!RST_N || !wait_tick || timeout) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
        err_q <= RST_N && timeout;
    end

    assign FETCH_ERR = err_q;
`else
    wire unused_timeout_cfg = (TIMEOUT_CYC != 0);

    assign timeout   = 1'b0;
    assign FETCH_ERR = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        vld_d   = vld_q;
        case (state_q)
            S_FETCH: begin
                if (PC_LD) begin
                    // Redirect wins over a same-cycle return; that data belongs to the old path.
                    pc_d = PC_IN;
                end else if (MEM_RDY) begin
                    ir_d    = MEM_DATA;
                    pc_d    = pc_q + 16'd1;
                    vld_d   = 1'b1;
                    state_d = S_HOLD;
                end else if (timeout) begin
                    state_d = S_RETRY;
                end
            end
            S_HOLD: begin
                if (PC_LD) begin
                    pc_d    = PC_IN;
                    vld_d   = 1'b0;
                    state_d = S_FETCH;
                end else if (!STALL) begin
                    vld_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_RETRY: begin
                if (PC_LD) begin
                    pc_d = PC_IN;
                end
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            vld_q   <= vld_d;
        end
    end

    assign MEM_REQ  = (state_q == S_FETCH);
    assign MEM_ADDR = pc_q;
    assign IR       = ir_q;
    assign IR_VALID = vld_q;
    assign PC       = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a transaction-level model, plus directed literal scenarios.
`timescale 1ns/1ps
module tb_instr_fetch;

    localparam logic [15:0] RST_PC = 16'h3000;
    localparam int          TO_CYC = 15;

    logic        CLK = 1'b0;
    logic        RST_N, STALL, PC_LD, MEM_RDY;
    logic [15:0] PC_IN, MEM_DATA;
    logic        MEM_REQ, IR_VALID, FETCH_ERR;
    logic [15:0] MEM_ADDR, IR, PC;

    instr_fetch #(.RESET_PC(RST_PC), .TIMEOUT_CYC(TO_CYC)) dut (
        .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .PC_LD(PC_LD), .PC_IN(PC_IN),
        .MEM_RDY(MEM_RDY), .MEM_DATA(MEM_DATA), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
        .IR(IR), .IR_VALID(IR_VALID), .PC(PC), .FETCH_ERR(FETCH_ERR)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // Model: the fetcher either owns an instruction (m_hold), sits out a retry bubble,
    // or is waiting on memory for m_pc.
    logic [15:0] m_pc = RST_PC;
    logic [15:0] m_ir = 16'h0000;
    bit          m_hold  = 1'b0;
    bit          m_retry = 1'b0;
    bit          m_err   = 1'b0;
    int          m_wait  = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!RST_N) begin
            m_pc = RST_PC; m_ir = 16'h0000; m_hold = 0; m_retry = 0; m_err = 0; m_wait = 0;
        end else begin
            m_err = 0;
            if (m_retry) begin
                m_retry = 0;
                if (PC_LD) m_pc = PC_IN;
            end else if (m_hold) begin
                if (PC_LD) begin
                    m_pc = PC_IN; m_hold = 0;
                end else if (!STALL) begin
                    m_hold = 0;
                end
                m_wait = 0;
            end else begin
                if (PC_LD) begin
                    m_pc = PC_IN; m_wait = 0;
                end else if (MEM_RDY) begin
                    m_ir = MEM_DATA; m_pc = 16'((32'(m_pc) + 1) % 65536); m_hold = 1; m_wait = 0;
                end else begin
                    m_wait++;
`ifdef INSTR_FETCH_TIMEOUT_EN
                    if (m_wait == TO_CYC) begin
                        m_err = 1; m_retry = 1; m_wait = 0;
                    end
`endif
                end
            end
        end
    endtask

    task automatic step();
        bit exp_req;
        @(posedge CLK);
        model_edge();
        #1;
        exp_req = !m_hold && !m_retry;
        chk("mem_req", MEM_REQ, exp_req);
        if (exp_req) chk("mem_addr", MEM_ADDR, m_pc);
        chk("ir", IR, m_ir);
        chk("ir_valid", IR_VALID, m_hold);
        chk("pc", PC, m_pc);
        chk("fetch_err", FETCH_ERR, m_err);
    endtask

    task automatic drive(input bit rst_n, input bit stall, input bit pc_ld,
                         input logic [15:0] pc_in, input bit rdy, input logic [15:0] data);
        RST_N = rst_n; STALL = stall; PC_LD = pc_ld; PC_IN = pc_in; MEM_RDY = rdy; MEM_DATA = data;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        int pct_tab [5] = '{0, 5, 50, 90, 100};
        drive(0, 0, 0, 16'h0, 0, 16'h0);
        step(); step();
        chk("rst_pc", PC, 16'h3000);
        chk("rst_ir", IR, 16'h0000);
        chk("rst_valid", IR_VALID, 1'b0);
        chk("rst_err", FETCH_ERR, 1'b0);
        chk("rst_req", MEM_REQ, 1'b1);
        chk("rst_addr", MEM_ADDR, 16'h3000);

        // Data returns two cycles after reset release.
        drive(1, 0, 0, 16'h0, 0, 16'h0);
        step(); step();
        chk("wait_addr", MEM_ADDR, 16'h3000);
        chk("wait_req", MEM_REQ, 1'b1);
        drive(1, 0, 0, 16'h0, 1, 16'h1261);
        step();
        chk("load_ir", IR, 16'h1261);
        chk("load_valid", IR_VALID, 1'b1);
        chk("load_pc", PC, 16'h3001);

        drive(1, 1, 0, 16'h0, 1, 16'hDEAD);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_ir", IR, 16'h1261);
            chk("stall_req", MEM_REQ, 1'b0);
        end
        drive(1, 0, 0, 16'h0, 0, 16'h0);
        step();
        chk("release_req", MEM_REQ, 1'b1);
        chk("release_addr", MEM_ADDR, 16'h3001);
        chk("release_ir", IR, 16'h1261);

        drive(1, 0, 1, 16'h4000, 1, 16'hBEEF);
        step();
        chk("flush_ir", IR, 16'h1261);
        chk("flush_valid", IR_VALID, 1'b0);
        chk("flush_addr", MEM_ADDR, 16'h4000);

        drive(1, 0, 1, 16'hFFFF, 0, 16'h0);
        step();
        chk("wrap_addr", MEM_ADDR, 16'hFFFF);
        drive(1, 0, 0, 16'h0, 1, 16'h5A5A);
        step();
        chk("wrap_pc", PC, 16'h0000);
        chk("wrap_ir", IR, 16'h5A5A);

        drive(1, 1, 1, 16'h3005, 0, 16'h0);
        step();
        chk("hold_ld_valid", IR_VALID, 1'b0);
        chk("hold_ld_addr", MEM_ADDR, 16'h3005);
        drive(0, 0, 0, 16'h0, 1, 16'h1111);
        step();
        chk("midfetch_rst_pc", PC, 16'h3000);
        chk("midfetch_rst_ir", IR, 16'h0000);
        chk("midfetch_rst_valid", IR_VALID, 1'b0);

        drive(1, 0, 0, 16'h0, 0, 16'h0);
`ifdef INSTR_FETCH_TIMEOUT_EN
        cycles = 0;
        while (cycles < 40) begin
            step();
            cycles++;
            if (FETCH_ERR === 1'b1) break;
        end
        chk("timeout_cycles", 16'(cycles), 16'd15);
        chk("retry_req", MEM_REQ, 1'b0);
        step();
        chk("retry_err_clear", FETCH_ERR, 1'b0);
        chk("retry_req_again", MEM_REQ, 1'b1);
        chk("retry_addr", MEM_ADDR, 16'h3000);
`else
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (FETCH_ERR !== 1'b0 || MEM_REQ !== 1'b1) cycles++;
        end
        chk("no_timeout_cycles", 16'(cycles), 16'd0);
`endif

        for (int blk = 0; blk < 15; blk++) begin
            int pct = pct_tab[blk % 5];
            for (int c = 0; c < 200; c++) begin
                logic [15:0] tgt;
                tgt = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF))
                                                  : 16'($urandom());
                drive($urandom_range(0, 99) >= 2, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 99) < 8, tgt,
                      $urandom_range(0, 99) < pct, 16'($urandom()));
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h3000, meaning the PC value loaded at reset.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 15, meaning the memory-wait limit in cycles when the timeout feature is compiled in.
REQ-003 SHALL have port CLK  input  1  the single system clock; all state updates on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port STALL  input  1  downstream register/execute stage not ready to consume IR.
REQ-006 SHALL have port PC_LD  input  1  load branch/jump target.
REQ-007 SHALL have port PC_IN  input  16  branch/jump target address.
REQ-008 SHALL have port MEM_RDY  input  1  memory read data valid.
REQ-009 SHALL have port MEM_DATA  input  16  memory read data.
REQ-010 SHALL have port MEM_REQ  output  1  instruction read request.
REQ-011 SHALL have port MEM_ADDR  output  16  instruction read address.
REQ-012 SHALL have port IR  output  16  instruction register, feeding the register-file stage (RD=IR[11:9], RS1=IR[8:6], RS2=IR[2:0]).
REQ-013 SHALL have port IR_VALID  output  1  IR holds a fetched, unconsumed instruction.
REQ-014 SHALL have port PC  output  16  address of the next instruction (LC-3 incremented-PC semantics).
REQ-015 SHALL have port FETCH_ERR  output  1  one-cycle memory-timeout pulse.

Function
REQ-016 SHALL implement a 3-state FSM: FETCH, HOLD, RETRY.
REQ-017 In FETCH: MEM_REQ=1, MEM_ADDR=PC, both stable until MEM_RDY is sampled high.
REQ-018 FETCH with MEM_RDY=1 and PC_LD=0: IR<=MEM_DATA, PC<=PC+1 (mod 2^16, 16'hFFFF wraps to 16'h0000), IR_VALID<=1, next state HOLD; load latency exactly one edge after MEM_RDY.
REQ-019 In HOLD: MEM_REQ=0, IR and PC held; if STALL=0 at an edge, IR_VALID<=0 and next state FETCH; if STALL=1, remain in HOLD indefinitely.
REQ-020 IR SHALL retain its last value whenever no new instruction is loaded, including while IR_VALID=0.
REQ-021 PC_LD=1 in any state SHALL set PC<=PC_IN and take priority over increment.
REQ-022 PC_LD=1 in HOLD SHALL flush: IR_VALID<=0, next state FETCH, regardless of STALL.
REQ-023 PC_LD=1 in FETCH simultaneous with MEM_RDY=1 SHALL discard MEM_DATA (IR unchanged, IR_VALID stays 0), stay in FETCH, and request PC_IN next cycle.
REQ-024 MEM_RDY while not in FETCH SHALL be ignored.
REQ-025 RETRY: MEM_REQ=0 for exactly one cycle, then FETCH at unchanged PC.

Reset
REQ-026 RST_N=0 at an edge SHALL force state FETCH, PC=RESET_PC, IR=16'h0000, IR_VALID=0, FETCH_ERR=0, timeout counter=0, overriding all other inputs including mid-fetch.
REQ-027 After RST_N deasserts, MEM_REQ SHALL be 1 with MEM_ADDR=RESET_PC in the first cycle.

Configuration
REQ-028 Macro INSTR_FETCH_TIMEOUT_EN defined: a wait counter SHALL count FETCH cycles without MEM_RDY; on reaching TIMEOUT_CYC, FETCH_ERR=1 for one cycle, counter cleared, next state RETRY.
REQ-029 Counter SHALL clear on entering FETCH, on MEM_RDY, and on PC_LD.
REQ-030 Macro not defined: no counter, FETCH waits indefinitely, RETRY unreachable, FETCH_ERR tied 0.

Verification
REQ-031 Reset then MEM_RDY=1 with MEM_DATA=16'h1261 two cycles later -> MEM_ADDR=16'h3000 while waiting, then IR=16'h1261, IR_VALID=1, PC=16'h3001.
REQ-032 HOLD with STALL=1 for 5 cycles, then 0 -> IR stable 5 cycles, MEM_REQ=0 throughout, then MEM_REQ=1 with MEM_ADDR=16'h3001.
REQ-033 PC_LD=1, PC_IN=16'h4000 in the same cycle as MEM_RDY=1 -> IR unchanged, IR_VALID=0, next MEM_ADDR=16'h4000.
REQ-034 PC=16'hFFFF, fetch completes -> PC=16'h0000.
REQ-035 RST_N=0 during FETCH at PC=16'h3005 -> next cycle PC=16'h3000, IR=16'h0000, IR_VALID=0.
REQ-036 With INSTR_FETCH_TIMEOUT_EN, MEM_RDY held 0 -> FETCH_ERR pulses after 15 FETCH cycles, MEM_REQ low one cycle, re-request same address; without macro, FETCH_ERR stays 0 for 100 cycles.
